// File: rtl/axis_frame_downmixer_if.sv
// AXI4-Stream bundle for the frame downmixer: data, valid, last and ready.
// The master modport drives the beat, the slave modport answers with ready.
interface axis_frame_downmixer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_downmixer.sv
// Reduces each multi-channel AXI4-Stream audio frame to one signed sample
// (average, channel select, peak magnitude or side), with decimation and framing-error counting.
module axis_frame_downmixer #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    i_s_axis_aclk,
    input  logic                    i_s_axis_areset,
    axis_frame_downmixer_if.slave   s_axis,
    axis_frame_downmixer_if.master  m_axis,
    input  logic [1:0]              i_mode,
    input  logic [2:0]              i_sel,
    input  logic [7:0]              i_decim,
    output logic                    o_frame_err,
    output logic [15:0]             o_err_count
);
    localparam int CW   = $clog2(NUM_CHANNELS);
    localparam int SW   = SAMPLE_WIDTH;
    localparam int SUMW = SW + CW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_CHANNELS - 1);
    localparam logic [3:0]    NCH       = 4'(NUM_CHANNELS);
    localparam logic [SW-1:0] MAX_POS   = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] MIN_NEG   = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic {ST_ACCUM, ST_RESYNC} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_b;
    logic [7:0]             r_d;
    logic [1:0]             r_mode;
    logic [2:0]             r_sel;
    logic [7:0]             r_decim;
    logic [SUMW-1:0]        r_sum;
    logic [SW-1:0]          r_peak;
    logic [SW-1:0]          r_selCap;
    logic [SW-1:0]          r_ch0;
    logic [SW-1:0]          r_ch1;
    logic                   r_oValid;
    logic [DATA_WIDTH-1:0]  r_oData;
    logic                   r_frameErr;
    logic [15:0]            r_errCount;

    logic [SW-1:0]          w_sample;
    logic [SW-1:0]          w_abs;
    logic                   w_first;
    logic                   w_lastBeat;
    logic [2:0]             w_selEff;
    logic [2:0]             w_selIdx;
    logic [SUMW-1:0]        w_sampleExt;
    logic signed [SUMW-1:0] w_sumNext;
    logic [SW-1:0]          w_peakNext;
    logic [SW-1:0]          w_selNext;
    logic [SW-1:0]          w_ch0Next;
    logic [SW-1:0]          w_ch1Next;
    logic signed [SW:0]     w_diff;
    logic signed [SUMW-1:0] w_avgFull;
    logic signed [SW:0]     w_halfDiff;
    logic [SW-1:0]          w_result;
    logic                   w_sReady;
    logic                   w_accept;
    logic                   w_unusedBits;

    assign w_sample     = s_axis.tdata[SW-1:0];
    assign w_unusedBits = &{1'b0, s_axis.tdata[DATA_WIDTH-1:SW]};
    assign w_first      = (r_b == '0);
    assign w_lastBeat   = (r_b == LAST_BEAT);

    // Beat 0 sees the live controls; later beats use the values latched at beat 0.
    always_comb begin
        w_abs       = w_sample;
        if (w_sample == MIN_NEG) begin
            w_abs = MAX_POS;
        end else if (w_sample[SW-1]) begin
            w_abs = -w_sample;
        end
        w_selEff    = w_first ? i_sel : r_sel;
        w_selIdx    = ({1'b0, w_selEff} >= NCH) ? 3'd0 : w_selEff;
        w_sampleExt = {{CW{w_sample[SW-1]}}, w_sample};
        w_sumNext   = w_first ? w_sampleExt : r_sum + w_sampleExt;
        w_peakNext  = (w_first || (w_abs > r_peak)) ? w_abs : r_peak;
        w_selNext   = (3'(r_b) == w_selIdx) ? w_sample : r_selCap;
        w_ch0Next   = w_first ? w_sample : r_ch0;
        w_ch1Next   = (r_b == CW'(1)) ? w_sample : r_ch1;
        w_diff      = {w_ch0Next[SW-1], w_ch0Next} - {w_ch1Next[SW-1], w_ch1Next};
        w_avgFull   = w_sumNext >>> CW;
        w_halfDiff  = w_diff >>> 1;
        case (r_mode)
            2'd0:    w_result = w_avgFull[SW-1:0];
            2'd1:    w_result = w_selNext;
            2'd2:    w_result = w_peakNext;
            default: w_result = w_halfDiff[SW-1:0];
        endcase
    end

    // The closing beat may stall only when it would load a still-occupied output register.
    assign w_sReady = !i_s_axis_areset &&
                      ((r_state == ST_RESYNC) || !w_lastBeat || !r_oValid ||
                       m_axis.tready || (r_d != 8'd0));
    assign w_accept = s_axis.tvalid && w_sReady;

    always_ff @(posedge i_s_axis_aclk) begin
        if (i_s_axis_areset) begin
            r_state    <= ST_ACCUM;
            r_b        <= '0;
            r_d        <= 8'd0;
            r_mode     <= 2'd0;
            r_sel      <= 3'd0;
            r_decim    <= 8'd0;
            r_sum      <= '0;
            r_peak     <= '0;
            r_selCap   <= '0;
            r_ch0      <= '0;
            r_ch1      <= '0;
            r_oValid   <= 1'b0;
            r_oData    <= '0;
            r_frameErr <= 1'b0;
            r_errCount <= 16'd0;
        end else begin
            r_frameErr <= 1'b0;
            if (m_axis.tready) begin
                r_oValid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    ST_ACCUM: begin
                        if (w_first) begin
                            r_mode  <= i_mode;
                            r_sel   <= i_sel;
                            r_decim <= i_decim;
                        end
                        r_sum    <= w_sumNext;
                        r_peak   <= w_peakNext;
                        r_selCap <= w_selNext;
                        r_ch0    <= w_ch0Next;
                        r_ch1    <= w_ch1Next;
                        if (s_axis.tlast != w_lastBeat) begin
                            r_frameErr <= 1'b1;
                            if (r_errCount != 16'hFFFF) begin
                                r_errCount <= r_errCount + 16'd1;
                            end
                            r_b <= '0;
                            if (w_lastBeat) begin
                                r_state <= ST_RESYNC;
                            end
                        end else if (w_lastBeat) begin
                            r_b <= '0;
                            if (r_d == 8'd0) begin
                                r_oValid <= 1'b1;
                                r_oData  <= {{(DATA_WIDTH-SW){w_result[SW-1]}}, w_result};
                            end
                            r_d <= (r_d == r_decim) ? 8'd0 : r_d + 8'd1;
                        end else begin
                            r_b <= r_b + CW'(1);
                        end
                    end
                    default: begin
                        r_b <= '0;
                        if (s_axis.tlast) begin
                            r_state <= ST_ACCUM;
                        end
                    end
                endcase
            end
        end
    end

    assign s_axis.tready = w_sReady;
    assign m_axis.tvalid = r_oValid;
    assign m_axis.tdata  = r_oData;
    // Every reduced sample stands alone on the output stream.
    assign m_axis.tlast  = 1'b1;
    assign o_frame_err   = r_frameErr;
    assign o_err_count   = r_errCount;
endmodule

// File: tb/tb_axis_frame_downmixer.sv
// Directed bench for axis_frame_downmixer with two channels: reduction modes,
// back-pressure, framing errors, decimation and mid-frame reset.
module tb_axis_frame_downmixer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  sel = 3'd0;
    logic [7:0]  decim = 8'd0;
    logic        frameErr;
    logic [15:0] errCount;
    int          assertCount = 0;
    int          failCount = 0;

    axis_frame_downmixer_if #(.DATA_WIDTH(32)) sIf ();
    axis_frame_downmixer_if #(.DATA_WIDTH(32)) mIf ();

    axis_frame_downmixer #(
        .NUM_CHANNELS(2),
        .SAMPLE_WIDTH(24),
        .DATA_WIDTH(32)
    ) dut (
        .i_s_axis_aclk   (clk),
        .i_s_axis_areset (rst),
        .s_axis          (sIf.slave),
        .m_axis          (mIf.master),
        .i_mode          (mode),
        .i_sel           (sel),
        .i_decim         (decim),
        .o_frame_err     (frameErr),
        .o_err_count     (errCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input beat and hold it until the DUT takes it, with a bounded wait.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int waitCycles = 0;
        sIf.tdata  = data;
        sIf.tlast  = last;
        sIf.tvalid = 1'b1;
        while (sIf.tready !== 1'b1 && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (waitCycles >= 50) begin
            checkOutput("tready_timeout", 32'(sIf.tready), 32'd1);
        end
        tick();
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
    endtask

    task automatic runFrame(input string tag, input logic [31:0] ch0, input logic [31:0] ch1,
                            input logic [31:0] expected);
        applyStimulus(ch0, 1'b0);
        applyStimulus(ch1, 1'b1);
        checkOutput({tag, "_valid"}, 32'(mIf.tvalid), 32'd1);
        checkOutput({tag, "_data"}, mIf.tdata, expected);
        tick();
    endtask

    initial begin
        sIf.tvalid = 1'b0;
        sIf.tdata  = 32'd0;
        sIf.tlast  = 1'b0;
        mIf.tready = 1'b1;
        tick();
        tick();
        checkOutput("reset_s_tready", 32'(sIf.tready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_s_tready", 32'(sIf.tready), 32'd1);
        checkOutput("post_reset_m_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("post_reset_m_tdata", mIf.tdata, 32'd0);
        checkOutput("post_reset_frame_err", 32'(frameErr), 32'd0);
        checkOutput("post_reset_err_count", 32'(errCount), 32'd0);
        tick();

        $display("[TB] reduction modes");
        mode = 2'd0;
        applyStimulus(32'd100, 1'b0);
        checkOutput("avg_no_early_valid", 32'(mIf.tvalid), 32'd0);
        applyStimulus(32'hFFFFFED3, 1'b1);
        checkOutput("avg_valid", 32'(mIf.tvalid), 32'd1);
        checkOutput("avg_data", mIf.tdata, 32'hFFFFFF9B);
        tick();
        checkOutput("avg_drained", 32'(mIf.tvalid), 32'd0);
        mode = 2'd2;
        runFrame("peak", 32'hFF800000, 32'd5, 32'h007FFFFF);
        mode = 2'd1;
        sel  = 3'd1;
        runFrame("select_ch1", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE);
        sel  = 3'd3;
        runFrame("select_oob", 32'd7, 32'hFFFFFFFE, 32'h00000007);
        mode = 2'd3;
        runFrame("side_pos", 32'd10, 32'hFFFFFFFB, 32'h00000007);
        runFrame("side_neg", 32'hFFFFFFFB, 32'd10, 32'hFFFFFFF8);

        $display("[TB] back-pressure");
        mode = 2'd0;
        mIf.tready = 1'b0;
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd1, 1'b1);
        checkOutput("bp_first_valid", 32'(mIf.tvalid), 32'd1);
        checkOutput("bp_first_data", mIf.tdata, 32'd1);
        applyStimulus(32'd3, 1'b0);
        sIf.tdata  = 32'd3;
        sIf.tlast  = 1'b1;
        sIf.tvalid = 1'b1;
        #1;
        checkOutput("bp_last_beat_stalled", 32'(sIf.tready), 32'd0);
        tick();
        tick();
        checkOutput("bp_still_stalled", 32'(sIf.tready), 32'd0);
        checkOutput("bp_held_valid", 32'(mIf.tvalid), 32'd1);
        checkOutput("bp_held_data", mIf.tdata, 32'd1);
        mIf.tready = 1'b1;
        #1;
        checkOutput("bp_released", 32'(sIf.tready), 32'd1);
        tick();
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
        checkOutput("bp_second_valid", 32'(mIf.tvalid), 32'd1);
        checkOutput("bp_second_data", mIf.tdata, 32'd3);
        tick();
        checkOutput("bp_drained", 32'(mIf.tvalid), 32'd0);

        $display("[TB] framing errors");
        applyStimulus(32'd9, 1'b1);
        checkOutput("early_last_pulse", 32'(frameErr), 32'd1);
        checkOutput("early_last_count", 32'(errCount), 32'd1);
        checkOutput("early_last_no_output", 32'(mIf.tvalid), 32'd0);
        tick();
        checkOutput("early_last_pulse_end", 32'(frameErr), 32'd0);
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'd6, 1'b0);
        checkOutput("missing_last_pulse", 32'(frameErr), 32'd1);
        checkOutput("missing_last_count", 32'(errCount), 32'd2);
        applyStimulus(32'd7, 1'b0);
        applyStimulus(32'd8, 1'b1);
        checkOutput("resync_no_pulse", 32'(frameErr), 32'd0);
        checkOutput("resync_count", 32'(errCount), 32'd2);
        checkOutput("resync_no_output", 32'(mIf.tvalid), 32'd0);
        runFrame("recover", 32'd4, 32'd6, 32'd5);

        $display("[TB] decimation");
        decim = 8'd2;
        mode  = 2'd1;
        sel   = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            logic emit;
            emit = (k == 1) || (k == 4);
            applyStimulus(32'(k), 1'b0);
            applyStimulus(32'd0, 1'b1);
            checkOutput($sformatf("decim_valid_%0d", k), 32'(mIf.tvalid), 32'(emit));
            if (emit) begin
                checkOutput($sformatf("decim_data_%0d", k), mIf.tdata, 32'(k));
            end
            tick();
        end
        decim = 8'd0;

        $display("[TB] reset mid-frame");
        mode = 2'd0;
        mIf.tready = 1'b0;
        applyStimulus(32'd10, 1'b0);
        applyStimulus(32'd20, 1'b1);
        checkOutput("pre_reset_held_data", mIf.tdata, 32'd15);
        applyStimulus(32'd50, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("mid_reset_s_tready", 32'(sIf.tready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("after_reset_m_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("after_reset_m_tdata", mIf.tdata, 32'd0);
        checkOutput("after_reset_err_count", 32'(errCount), 32'd0);
        mIf.tready = 1'b1;
        tick();
        runFrame("after_reset_frame", 32'd20, 32'hFFFFFFFC, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
